// File: rtl/dot_acc_pkg.sv
// Shared types and width helpers for the dot_accumulator block.
package dot_acc_pkg;

  typedef enum logic {ST_ACC, ST_FLUSH} dot_acc_state_t;

  // Guard bits needed so that LEN full-scale products cannot overflow.
  function automatic int unsigned guard_bits(input int unsigned len);
    return $clog2(len);
  endfunction

endpackage

// File: rtl/dot_accumulator.sv
// Sums LEN unsigned products per block and emits one full-precision result per block.
// Optional macro DOT_ACC_LAST_EN adds s_last for early block termination.
module dot_accumulator
  import dot_acc_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned LEN = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [2*N-1:0]                       s_m,
`ifdef DOT_ACC_LAST_EN
  input  logic                                 s_last,
`endif
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [2*N+guard_bits(LEN)-1:0]       m_sum,
  output logic [$clog2(LEN+1)-1:0]             m_count
);

  localparam int unsigned GW = guard_bits(LEN);
  localparam int unsigned AW = 2*N + GW;
  localparam int unsigned CW = $clog2(LEN+1);

  dot_acc_state_t state_q, state_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           m_valid_q, m_valid_d;
  logic [AW-1:0]  m_sum_q, m_sum_d;
  logic [CW-1:0]  m_count_q, m_count_d;

  logic [AW-1:0]  acc_next;
  logic [CW-1:0]  cnt_inc;
  logic           slot_free;
  logic           is_final;

  assign acc_next  = acc_q + AW'(s_m);
  assign cnt_inc   = cnt_q + CW'(1);
  assign slot_free = !m_valid_q || m_ready;

`ifdef DOT_ACC_LAST_EN
  assign is_final = (cnt_q == CW'(LEN-1)) || s_last;
`else
  assign is_final = (cnt_q == CW'(LEN-1));
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_sum_d   = m_sum_q;
    m_count_d = m_count_q;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      ST_ACC: begin
        if (s_valid) begin
          if (is_final && slot_free) begin
            m_sum_d   = acc_next;
            m_count_d = cnt_inc;
            m_valid_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_inc;
            // Slot busy at block end: park the finished block in acc/cnt and stall input.
            if (is_final) state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          m_sum_d   = acc_q;
          m_count_d = cnt_q;
          m_valid_d = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_sum_q   <= '0;
      m_count_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_sum_q   <= m_sum_d;
      m_count_q <= m_count_d;
    end
  end

  assign s_ready = (state_q == ST_ACC);
  assign m_valid = m_valid_q;
  assign m_sum   = m_sum_q;
  assign m_count = m_count_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Testbench for dot_accumulator: directed checks on an N=8/LEN=4 instance and
// randomized blocks on an N=32/LEN=16 instance against a queue-based reference.
module tb_dot_accumulator;

  logic clk;
  logic rst;

  int n_cmp;
  int n_fail;

  // Small instance: N=8, LEN=4 -> AW=18, CW=3
  logic        s_valid_s, s_ready_s, m_valid_s, m_ready_s;
  logic [15:0] s_m_s;
  logic [17:0] m_sum_s;
  logic [2:0]  m_count_s;
`ifdef DOT_ACC_LAST_EN
  logic        s_last_s;
  logic        s_last_l;
`endif

  // Large instance: N=32, LEN=16 -> AW=68, CW=5
  logic        s_valid_l, s_ready_l, m_valid_l, m_ready_l;
  logic [63:0] s_m_l;
  logic [67:0] m_sum_l;
  logic [4:0]  m_count_l;

  dot_accumulator #(.N(8), .LEN(4)) dut_s (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid_s),
    .s_ready (s_ready_s),
    .s_m     (s_m_s),
`ifdef DOT_ACC_LAST_EN
    .s_last  (s_last_s),
`endif
    .m_valid (m_valid_s),
    .m_ready (m_ready_s),
    .m_sum   (m_sum_s),
    .m_count (m_count_s)
  );

  dot_accumulator #(.N(32), .LEN(16)) dut_l (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid_l),
    .s_ready (s_ready_l),
    .s_m     (s_m_l),
`ifdef DOT_ACC_LAST_EN
    .s_last  (s_last_l),
`endif
    .m_valid (m_valid_l),
    .m_ready (m_ready_l),
    .m_sum   (m_sum_l),
    .m_count (m_count_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [67:0] exp_sum_q[$];
  int          exp_cnt_q[$];
  logic [67:0] got_sum_q[$];
  int          got_cnt_q[$];
  bit          random_phase;

  // Output monitor on the large instance; values at negedge are those the next posedge uses.
  always @(negedge clk) begin
    if (!rst && m_valid_l && m_ready_l) begin
      got_sum_q.push_back(m_sum_l);
      got_cnt_q.push_back(int'(m_count_l));
    end
  end

  // Random consumer back-pressure on the large instance.
  initial begin
    m_ready_l = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (random_phase) m_ready_l = ($urandom_range(0, 3) != 0);
      else              m_ready_l = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_s(input logic [15:0] v, input logic last);
    int unsigned guard;
    guard = 0;
    s_valid_s = 1'b1;
    s_m_s     = v;
`ifdef DOT_ACC_LAST_EN
    s_last_s  = last;
`endif
    while (!s_ready_s && guard < 1000) begin
      step();
      guard++;
    end
    if (!s_ready_s) check("send_s_timeout", s_ready_s, 1);
    step();
    s_valid_s = 1'b0;
    s_m_s     = 16'hAAAA;
`ifdef DOT_ACC_LAST_EN
    s_last_s  = 1'b0;
`endif
  endtask

  task automatic send_l(input logic [63:0] v, input logic last);
    int unsigned guard;
    guard = 0;
    s_valid_l = 1'b1;
    s_m_l     = v;
`ifdef DOT_ACC_LAST_EN
    s_last_l  = last;
`endif
    while (!s_ready_l && guard < 1000) begin
      step();
      guard++;
    end
    if (!s_ready_l) check("send_l_timeout", s_ready_l, 1);
    step();
    s_valid_l = 1'b0;
    s_m_l     = 64'hDEAD_BEEF_DEAD_BEEF;
`ifdef DOT_ACC_LAST_EN
    s_last_l  = 1'b0;
`endif
  endtask

  initial begin
    int unsigned len;
    int unsigned guard;
    int unsigned n;
    logic [63:0] p;
    logic [67:0] sum;

    n_cmp = 0;
    n_fail = 0;
    random_phase = 1'b0;
    rst = 1'b1;
    s_valid_s = 1'b0; s_m_s = '0; m_ready_s = 1'b1;
    s_valid_l = 1'b0; s_m_l = '0;
`ifdef DOT_ACC_LAST_EN
    s_last_s = 1'b0;
    s_last_l = 1'b0;
`endif

    // Reset state
    step(); step();
    check("rst_m_valid", m_valid_s, 0);
    check("rst_m_sum",   m_sum_s,   0);
    check("rst_m_count", m_count_s, 0);
    check("rst_m_valid_l", m_valid_l, 0);
    rst = 1'b0;
    step();
    check("rst_s_ready", s_ready_s, 1);

    // Products 1..4 back-to-back
    send_s(16'd1, 1'b0); check("b1_mv_1", m_valid_s, 0);
    send_s(16'd2, 1'b0); check("b1_mv_2", m_valid_s, 0);
    send_s(16'd3, 1'b0); check("b1_mv_3", m_valid_s, 0);
    send_s(16'd4, 1'b0);
    check("b1_m_valid", m_valid_s, 1);
    check("b1_m_sum",   m_sum_s,   10);
    check("b1_m_count", m_count_s, 4);
    step();
    check("b1_m_valid_drop", m_valid_s, 0);

    // Idle cycles with garbage on s_m must not disturb the accumulator
    repeat (3) step();

    // Full-scale products: no truncation
    repeat (4) send_s(16'hFFFF, 1'b0);
    check("max_m_valid", m_valid_s, 1);
    check("max_m_sum",   m_sum_s,   18'h3FFFC);
    check("max_m_count", m_count_s, 4);
    step();

    // Back-pressure: A held, B parks in flush
    m_ready_s = 1'b0;
    repeat (4) send_s(16'd1, 1'b0);
    check("bp_a_valid", m_valid_s, 1);
    check("bp_a_sum",   m_sum_s,   4);
    check("bp_a_ready", s_ready_s, 1);
    repeat (4) send_s(16'd2, 1'b0);
    check("bp_flush_ready", s_ready_s, 0);
    check("bp_a_held_sum",  m_sum_s,   4);
    step(); step();
    check("bp_a_held_valid", m_valid_s, 1);
    check("bp_a_held_sum2",  m_sum_s,   4);
    check("bp_still_stall",  s_ready_s, 0);
    m_ready_s = 1'b1;
    step();
    check("bp_b_valid", m_valid_s, 1);
    check("bp_b_sum",   m_sum_s,   8);
    check("bp_b_count", m_count_s, 4);
    check("bp_ready_back", s_ready_s, 1);
    step();
    check("bp_b_drained", m_valid_s, 0);

    // Reset mid-block with a held result
    m_ready_s = 1'b0;
    repeat (4) send_s(16'd1, 1'b0);
    send_s(16'd9, 1'b0);
    send_s(16'd9, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", m_valid_s, 0);
    check("mid_rst_m_sum",   m_sum_s,   0);
    step();
    rst = 1'b0;
    m_ready_s = 1'b1;
    repeat (4) send_s(16'd1, 1'b0);
    check("post_rst_sum",   m_sum_s,   4);
    check("post_rst_count", m_count_s, 4);
    step();

`ifdef DOT_ACC_LAST_EN
    // Early end of block via s_last
    send_s(16'd5, 1'b0);
    send_s(16'd7, 1'b1);
    check("last_valid", m_valid_s, 1);
    check("last_sum",   m_sum_s,   12);
    check("last_count", m_count_s, 2);
    step();
    repeat (4) send_s(16'd1, 1'b0);
    check("last_full_sum",   m_sum_s,   4);
    check("last_full_count", m_count_s, 4);
    step();
`endif

    // Randomized blocks on the large instance
    random_phase = 1'b1;
    for (int b = 0; b < 512; b++) begin
`ifdef DOT_ACC_LAST_EN
      len = $urandom_range(1, 16);
`else
      len = 16;
`endif
      sum = '0;
      for (int unsigned i = 0; i < len; i++) begin
        p = {$urandom(), $urandom()};
        if ((b % 8) == 0) p = '1;
        sum = sum + 68'(p);
        repeat ($urandom_range(0, 2)) step();
        send_l(p, i == len - 1);
      end
      exp_sum_q.push_back(sum);
      exp_cnt_q.push_back(int'(len));
    end
    guard = 0;
    while (got_sum_q.size() < exp_sum_q.size() && guard < 5000) begin
      step();
      guard++;
    end
    repeat (20) step();
    check("rand_result_count", got_sum_q.size(), exp_sum_q.size());
    n = (got_sum_q.size() < exp_sum_q.size()) ? got_sum_q.size() : exp_sum_q.size();
    for (int unsigned k = 0; k < n; k++) begin
      check($sformatf("rand_sum_%0d", k),   got_sum_q[k], exp_sum_q[k]);
      check($sformatf("rand_count_%0d", k), got_cnt_q[k], exp_cnt_q[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
